// File: rtl/tile_ram_pkg.sv
// tile_ram_pkg: shared constants, FSM/requester encodings and range helper for the tile RAM write arbiter
// No ports; imported by tile_clear_counter and tile_ram_wr_arbiter.
package tile_ram_pkg;
  localparam int MAX_X = 40;
  localparam int MAX_Y = 20;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 7;
  localparam int ROW_W = 5;
  localparam int COL_W = 7;
  localparam logic [DATA_W-1:0] CLR_CHAR = 7'h20;
  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_e;
  typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_e;
  function automatic logic tile_in_range(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:COL_W] < ROW_W'(MAX_Y) && addr[COL_W-1:0] < COL_W'(MAX_X);
  endfunction
endpackage

// File: rtl/tile_clear_counter.sv
// tile_clear_counter: row/col sweep over the visible tiles for the screen-clear engine
// Ports: clk, reset (async active-low), start (load 0,0), en (advance one tile),
//        row/col (next tile to issue), last (row MAX_Y-1, col MAX_X-1).
module tile_clear_counter
  import tile_ram_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             en,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic             col_end;
  assign col_end = col_q == COL_W'(MAX_X - 1);
  assign last = col_end && row_q == ROW_W'(MAX_Y - 1);
  assign row = row_q;
  assign col = col_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      row_q <= '0;
      col_q <= '0;
    end else if (start) begin
      row_q <= '0;
      col_q <= '0;
    end else if (en) begin
      col_q <= col_end ? '0 : col_q + COL_W'(1);
      row_q <= !col_end ? row_q : last ? '0 : row_q + ROW_W'(1);
    end
endmodule

// File: rtl/tile_ram_wr_arbiter.sv
// tile_ram_wr_arbiter: round-robin arbiter for the tile RAM write port with a screen-clear engine
// Ports: clk, reset (async active-low); req/addr/data/gnt for requesters A and B;
//        clr_start/clr_busy/clr_done for the clear engine; addr_err reject pulse;
//        ram_we/ram_addr/ram_din drive the RAM write port. All outputs are registered.
// Optional: TILE_ADDR_CHECK_EN grants out-of-range requests without writing and pulses addr_err.
module tile_ram_wr_arbiter
  import tile_ram_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  output logic              gnt_a,
  input  logic              req_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_b,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              addr_err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din
);
  state_e            state_q, state_d;
  req_e              last_q, last_d, win;
  logic              pend_q, pend_d, tail_q, tail_d;
  logic              we_q, we_d, gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d, sel_addr;
  logic [DATA_W-1:0] din_q, din_d, sel_data;
  logic              bad, cnt_start, cnt_en, cnt_last;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  tile_clear_counter u_cnt (
    .clk  (clk),
    .reset(reset),
    .start(cnt_start),
    .en   (cnt_en),
    .row  (row),
    .col  (col),
    .last (cnt_last)
  );
  assign win = req_b && (!req_a || last_q == REQ_A) ? REQ_B : REQ_A;
  assign sel_addr = win == REQ_B ? addr_b : addr_a;
  assign sel_data = win == REQ_B ? data_b : data_a;
`ifdef TILE_ADDR_CHECK_EN
  assign bad = !tile_in_range(sel_addr);
`else
  assign bad = 1'b0;
`endif
  // tail_q marks the cycle after the last clear write, which reports clr_done before IDLE
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    pend_d = pend_q;
    tail_d = tail_q;
    we_d = 1'b0;
    gnt_a_d = 1'b0;
    gnt_b_d = 1'b0;
    done_d = 1'b0;
    err_d = 1'b0;
    busy_d = busy_q;
    addr_d = addr_q;
    din_d = din_q;
    cnt_start = 1'b0;
    cnt_en = 1'b0;
    case (state_q)
      IDLE:
        if (pend_q || clr_start) begin
          state_d = CLEAR;
          pend_d = 1'b0;
          cnt_start = 1'b1;
        end else if (req_a || req_b) begin
          state_d = WRITE;
          last_d = win;
          gnt_a_d = win == REQ_A;
          gnt_b_d = win == REQ_B;
          addr_d = sel_addr;
          din_d = sel_data;
          we_d = !bad;
          err_d = bad;
        end
      WRITE: begin
        state_d = IDLE;
        pend_d = pend_q || clr_start;
      end
      CLEAR:
        if (tail_q) begin
          state_d = IDLE;
          tail_d = 1'b0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          cnt_en = 1'b1;
          we_d = 1'b1;
          addr_d = {row, col};
          din_d = CLR_CHAR;
          busy_d = 1'b1;
          tail_d = cnt_last;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      last_q <= REQ_B;
      pend_q <= 1'b0;
      tail_q <= 1'b0;
      we_q <= 1'b0;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      din_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      pend_q <= pend_d;
      tail_q <= tail_d;
      we_q <= we_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      addr_q <= addr_d;
      din_q <= din_d;
    end
  assign ram_we = we_q;
  assign ram_addr = addr_q;
  assign ram_din = din_q;
  assign gnt_a = gnt_a_q;
  assign gnt_b = gnt_b_q;
  assign clr_busy = busy_q;
  assign clr_done = done_q;
  assign addr_err = err_q;
endmodule

// File: tb/tb_tile_ram_wr_arbiter.sv
// tb_tile_ram_wr_arbiter: self-checking bench for tile_ram_wr_arbiter (vectors, clear/reset sequences, random requesters)
module tb_tile_ram_wr_arbiter;
  import tile_ram_pkg::*;
  logic clk = 1'b0, reset = 1'b0, req_a = 1'b0, req_b = 1'b0, clr_start = 1'b0;
  logic [ADDR_W-1:0] addr_a = '0, addr_b = '0, ram_addr;
  logic [DATA_W-1:0] data_a = '0, data_b = '0, ram_din;
  logic gnt_a, gnt_b, clr_busy, clr_done, addr_err, ram_we;
  int checks = 0, errors = 0;
  typedef struct {
    logic ra; logic [11:0] aa; logic [6:0] da;
    logic rb; logic [11:0] ab; logic [6:0] db;
    logic ga; logic gb; logic we; logic err; logic [11:0] addr; logic [6:0] din;
  } vec_t;
  vec_t vt[8];
  int nwr, dones, bad, busy_bad, gbad, ng;
  logic seen, hit, we_at_done, busy_at_done, pa, pb, da_prev, db_prev, gprev, lastw_b;
  logic exp_any, exp_a, exp_b;
  logic [11:0] a_first, a_40, a_last, ta, tb_a;
  logic [6:0] xa, xb;

  always #5 clk = ~clk;

  tile_ram_wr_arbiter dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .gnt_a(gnt_a),
    .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .gnt_b(gnt_b),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done), .addr_err(addr_err),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; req_a = 1'b0; req_b = 1'b0; clr_start = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  function automatic logic [11:0] clr_addr(input int k);
    logic [4:0] r;
    logic [6:0] c;
    r = 5'(k / MAX_X);
    c = 7'(k % MAX_X);
    return {r, c};
  endfunction

  function automatic logic [11:0] rnd_addr();
    logic [4:0] r;
    logic [6:0] c;
    r = 5'($urandom_range(0, MAX_Y - 1));
    c = 7'($urandom_range(0, MAX_X - 1));
    return {r, c};
  endfunction

  initial begin
    vt[0] = '{1, 12'h005, 7'h41, 0, 12'h000, 7'h00, 1, 0, 1, 0, 12'h005, 7'h41};
    vt[1] = '{1, 12'h010, 7'h43, 1, 12'h081, 7'h42, 0, 1, 1, 0, 12'h081, 7'h42};
    vt[2] = '{1, 12'h010, 7'h43, 1, 12'h082, 7'h44, 1, 0, 1, 0, 12'h010, 7'h43};
    vt[3] = '{0, 12'h000, 7'h00, 1, 12'h100, 7'h45, 0, 1, 1, 0, 12'h100, 7'h45};
    vt[4] = '{0, 12'h000, 7'h00, 1, 12'h101, 7'h46, 0, 1, 1, 0, 12'h101, 7'h46};
    vt[5] = '{1, 12'h9A7, 7'h47, 1, 12'h000, 7'h48, 1, 0, 1, 0, 12'h9A7, 7'h47};
`ifdef TILE_ADDR_CHECK_EN
    vt[6] = '{1, 12'h028, 7'h49, 0, 12'h000, 7'h00, 1, 0, 0, 1, 12'h028, 7'h49};
`else
    vt[6] = '{1, 12'h028, 7'h49, 0, 12'h000, 7'h00, 1, 0, 1, 0, 12'h028, 7'h49};
`endif
    vt[7] = '{0, 12'h000, 7'h00, 0, 12'h000, 7'h00, 0, 0, 0, 0, 12'h028, 7'h49};

    // reset state, sampled while reset is held
    tick();
    chk("rst ram_we", ram_we, 0);
    chk("rst ram_addr", ram_addr, 0);
    chk("rst ram_din", ram_din, 0);
    chk("rst gnt_a", gnt_a, 0);
    chk("rst gnt_b", gnt_b, 0);
    chk("rst clr_busy", clr_busy, 0);
    chk("rst clr_done", clr_done, 0);
    chk("rst addr_err", addr_err, 0);
    do_reset();

    // vector table: one request pattern per IDLE cycle, checked in the WRITE cycle
    for (int i = 0; i < 8; i++) begin
      req_a = vt[i].ra; addr_a = vt[i].aa; data_a = vt[i].da;
      req_b = vt[i].rb; addr_b = vt[i].ab; data_b = vt[i].db;
      tick();
      chk($sformatf("vec%0d gnt_a", i), gnt_a, vt[i].ga);
      chk($sformatf("vec%0d gnt_b", i), gnt_b, vt[i].gb);
      chk($sformatf("vec%0d ram_we", i), ram_we, vt[i].we);
      chk($sformatf("vec%0d addr_err", i), addr_err, vt[i].err);
      chk($sformatf("vec%0d ram_addr", i), ram_addr, vt[i].addr);
      chk($sformatf("vec%0d ram_din", i), ram_din, vt[i].din);
      req_a = 1'b0; req_b = 1'b0;
      tick();
      chk($sformatf("vec%0d we_after", i), ram_we, 0);
    end

    // tie after reset: A first, B two cycles later
    do_reset();
    req_a = 1; addr_a = 12'h123; data_a = 7'h11;
    req_b = 1; addr_b = 12'h081; data_b = 7'h42;
    tick();
    chk("tie first gnt_a", gnt_a, 1);
    chk("tie first gnt_b", gnt_b, 0);
    chk("tie first addr", ram_addr, 12'h123);
    req_a = 0;
    tick();
    chk("tie gap we", ram_we, 0);
    tick();
    chk("tie second gnt_b", gnt_b, 1);
    chk("tie second addr", ram_addr, 12'h081);
    chk("tie second din", ram_din, 7'h42);
    req_b = 0;
    tick();

    // held request: one write every other cycle
    req_b = 1; addr_b = 12'h203; data_b = 7'h5A;
    nwr = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("held we c%0d", i), ram_we, i % 2);
      chk($sformatf("held gnt_b c%0d", i), gnt_b, i % 2);
      if (ram_we) nwr++;
    end
    req_b = 0;
    tick();
    chk("held writes", nwr, 5);
    chk("held stop", ram_we, 0);

    // clear sweep with A waiting; a second clr_start mid-clear must be ignored
    do_reset();
    req_a = 1; addr_a = 12'h200; data_a = 7'h33; clr_start = 1;
    tick();
    nwr = 0; dones = 0; bad = 0; busy_bad = 0; gbad = 0; seen = 0;
    a_first = '1; a_40 = '1; a_last = '1; we_at_done = 1; busy_at_done = 1;
    for (int c = 0; c < 1000 && !seen; c++) begin
      clr_start = (nwr == 100);
      tick();
      if (ram_we) begin
        if (ram_addr !== clr_addr(nwr) || ram_din !== CLR_CHAR) bad++;
        if (!clr_busy) busy_bad++;
        if (nwr == 0) a_first = ram_addr;
        if (nwr == 40) a_40 = ram_addr;
        a_last = ram_addr;
        nwr++;
      end
      if (gnt_a || gnt_b) gbad++;
      if (clr_done) begin
        dones++; seen = 1; we_at_done = ram_we; busy_at_done = clr_busy;
      end
    end
    clr_start = 0;
    chk("clr done seen", seen, 1);
    chk("clr writes", nwr, MAX_X * MAX_Y);
    chk("clr seq errors", bad, 0);
    chk("clr busy drops", busy_bad, 0);
    chk("clr grants during", gbad, 0);
    chk("clr first addr", a_first, 12'h000);
    chk("clr row1 addr", a_40, 12'h080);
    chk("clr last addr", a_last, 12'h9A7);
    chk("clr we at done", we_at_done, 0);
    chk("clr busy at done", busy_at_done, 0);
    tick();
    chk("clr done once", clr_done, 0);
    chk("post clr gnt_a", gnt_a, 1);
    chk("post clr addr", ram_addr, 12'h200);
    chk("post clr din", ram_din, 7'h33);
    req_a = 0;
    tick();

    // clr_start during WRITE becomes pending; reset mid-clear aborts
    do_reset();
    req_a = 1; addr_a = 12'h055; data_a = 7'h12;
    tick();
    chk("pend gnt_a", gnt_a, 1);
    req_a = 0; clr_start = 1;
    tick();
    clr_start = 0;
    tick();
    tick();
    chk("pend first we", ram_we, 1);
    chk("pend first addr", ram_addr, 12'h000);
    chk("pend first busy", clr_busy, 1);
    hit = 0;
    for (int c = 0; c < 400 && !hit; c++) begin
      tick();
      if (ram_we && ram_addr == 12'h18A) hit = 1;
    end
    chk("reach r3c10", hit, 1);
    reset = 0;
    #1;
    chk("abort we", ram_we, 0);
    chk("abort busy", clr_busy, 0);
    chk("abort addr", ram_addr, 0);
    chk("abort done", clr_done, 0);
    tick();
    tick();
    chk("abort no done", clr_done, 0);
    reset = 1;
    tick();
    clr_start = 1;
    tick();
    clr_start = 0;
    tick();
    chk("restart we", ram_we, 1);
    chk("restart addr", ram_addr, 12'h000);

    // random requesters against a transaction-level model
    do_reset();
    pa = 0; pb = 0; gprev = 0; lastw_b = 1; ng = 0; ta = '0; tb_a = '0; xa = '0; xb = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pa && $urandom_range(0, 1) == 1) begin pa = 1; ta = rnd_addr(); xa = 7'($urandom); end
      if (!pb && $urandom_range(0, 1) == 1) begin pb = 1; tb_a = rnd_addr(); xb = 7'($urandom); end
      req_a = pa; addr_a = ta; data_a = xa;
      req_b = pb; addr_b = tb_a; data_b = xb;
      da_prev = pa; db_prev = pb;
      tick();
      exp_any = (da_prev || db_prev) && !gprev;
      exp_b = exp_any && db_prev && (!da_prev || !lastw_b);
      exp_a = exp_any && !exp_b;
      chk("rand gnt_a", gnt_a, exp_a);
      chk("rand gnt_b", gnt_b, exp_b);
      chk("rand we", ram_we, exp_any);
      if (exp_any) begin
        chk("rand addr", ram_addr, exp_b ? tb_a : ta);
        chk("rand din", ram_din, exp_b ? xb : xa);
        lastw_b = exp_b;
        ng++;
      end
      if (gnt_a) pa = 0;
      if (gnt_b) pb = 0;
      gprev = exp_any;
    end
    req_a = 0; req_b = 0;
    tick();
    tick();
    chk("rand some grants", ng > 50, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
